nmi_scheduler: RTL and testbench

Timing and supervision controller for the game CPU's non-maskable interrupt. It divides the system clock into a low-rate tick and counts ticks into NMI periods. Each period it drives a fixed-width active-low NMI pulse to the 6502 core. A watchdog, cleared by the CPU's watchdog-write decode, forces a timed CPU reset when the program stops servicing it. It sits between the clock/reset block, the address decoder and the CPU core.

---
 rtl/nmi_scheduler_if.sv | 25 ++
 rtl/nmi_scheduler.sv | 160 ++++++++++++++++
 tb/tb_nmi_scheduler.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/nmi_scheduler_if.sv
// Handshake bundle between the NMI scheduler and its neighbours: control inputs
// from the clock/reset block and address decoder, and timing outputs to the CPU core.
interface nmi_scheduler_if #(
    parameter int NMI_PERIOD = 14
) ();
    localparam int PH_W = (NMI_PERIOD < 2) ? 1 : $clog2(NMI_PERIOD);

    logic            run;
    logic            nmi_mask;
    logic            wdog_clr;
    logic            tick;
    logic [PH_W-1:0] phase;
    logic            nmi_n;
    logic            cpu_rst;

    modport master (
        output run, nmi_mask, wdog_clr,
        input  tick, phase, nmi_n, cpu_rst
    );

    modport slave (
        input  run, nmi_mask, wdog_clr,
        output tick, phase, nmi_n, cpu_rst
    );
endinterface

// File: rtl/nmi_scheduler.sv
// NMI timing controller: prescaler -> tick -> phase counter -> periodic active-low NMI
// pulse, with a watchdog that forces a timed CPU reset when it is not cleared in time.
module nmi_scheduler #(
    parameter int PRESCALE     = 4096,
    parameter int NMI_PERIOD   = 14,
    parameter int NMI_WIDTH    = 32,
    parameter int WDOG_PERIODS = 8,
    parameter int RST_WIDTH    = 64
) (
    input  logic           clk,
    input  logic           rst,
    nmi_scheduler_if.slave bus
);
    localparam int PRE_W   = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
    localparam int PH_W    = (NMI_PERIOD < 2) ? 1 : $clog2(NMI_PERIOD);
    localparam int WD_W    = (WDOG_PERIODS < 1) ? 1 : $clog2(WDOG_PERIODS + 1);
    localparam int CNT_MAX = (NMI_WIDTH > RST_WIDTH) ? NMI_WIDTH : RST_WIDTH;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(NMI_PERIOD - 1);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [WD_W-1:0]  WD_LAST  = (WDOG_PERIODS == 0) ? WD_W'(0) : WD_W'(WDOG_PERIODS - 1);
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
    localparam logic [CNT_W-1:0] NMI_LAST = CNT_W'(NMI_WIDTH - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             WD_ON    = (WDOG_PERIODS != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WDRST = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q,   pre_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [WD_W-1:0]  wd_q,    wd_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             tick_q,  tick_d;
    logic             nmi_n_q, nmi_n_d;
    logic             cpu_rst_q, cpu_rst_d;

    logic adv_s;
    logic evt_s;
    logic expire_s;

    // The tick that wraps phase leaves phase at 0 while tick is high: that cycle is the NMI event.
    assign adv_s    = bus.run && (state_q != ST_WDRST);
    assign evt_s    = tick_q && (phase_q == {PH_W{1'b0}});
    assign expire_s = WD_ON && evt_s && !bus.wdog_clr && (wd_q == WD_LAST);

    // Next-state logic for the prescaler, phase, watchdog and pulse/reset state machine.
    always_comb begin
        pre_d     = pre_q;
        phase_d   = phase_q;
        wd_d      = wd_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        tick_d    = 1'b0;
        nmi_n_d   = 1'b1;
        cpu_rst_d = 1'b0;

        if (adv_s) begin
            if (pre_q == PRE_LAST) begin
                pre_d   = {PRE_W{1'b0}};
                tick_d  = 1'b1;
                phase_d = (phase_q == PH_LAST) ? {PH_W{1'b0}} : (phase_q + PH_ONE);
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end else begin
            pre_d = pre_q;
        end

        // Clear beats a same-cycle event so a decoder write on the event cycle keeps wd at 0.
        if (bus.wdog_clr) begin
            wd_d = {WD_W{1'b0}};
        end else if (evt_s && WD_ON) begin
            wd_d = wd_q + WD_ONE;
        end else begin
            wd_d = wd_q;
        end

        if (expire_s) begin
            state_d   = ST_WDRST;
            cnt_d     = RST_LAST;
            cpu_rst_d = 1'b1;
            pre_d     = {PRE_W{1'b0}};
            phase_d   = {PH_W{1'b0}};
            wd_d      = {WD_W{1'b0}};
            tick_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (evt_s && !bus.nmi_mask) begin
                        state_d = ST_PULSE;
                        cnt_d   = NMI_LAST;
                        nmi_n_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                        nmi_n_d = 1'b0;
                    end
                end
                ST_WDRST: begin
                    pre_d   = {PRE_W{1'b0}};
                    phase_d = {PH_W{1'b0}};
                    wd_d    = {WD_W{1'b0}};
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d     = cnt_q - CNT_ONE;
                        cpu_rst_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pre_q     <= {PRE_W{1'b0}};
            phase_q   <= {PH_W{1'b0}};
            wd_q      <= {WD_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            tick_q    <= 1'b0;
            nmi_n_q   <= 1'b1;
            cpu_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            phase_q   <= phase_d;
            wd_q      <= wd_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            nmi_n_q   <= nmi_n_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign bus.tick    = tick_q;
    assign bus.phase   = phase_q;
    assign bus.nmi_n   = nmi_n_q;
    assign bus.cpu_rst = cpu_rst_q;
endmodule

// File: tb/tb_nmi_scheduler.sv
// Directed bench for nmi_scheduler with small parameters; cycle c denotes register
// values after the c-th rising edge that samples rst=0.
module tb_nmi_scheduler;
    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    nmi_scheduler_if #(.NMI_PERIOD(14)) bus ();

    nmi_scheduler #(
        .PRESCALE    (4),
        .NMI_PERIOD  (14),
        .NMI_WIDTH   (3),
        .WDOG_PERIODS(4),
        .RST_WIDTH   (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic cyc_check(input int et, input int en, input int er, input int ep);
        chk("tick",    32'(bus.tick),    32'(et));
        chk("nmi_n",   32'(bus.nmi_n),   32'(en));
        chk("cpu_rst", 32'(bus.cpu_rst), 32'(er));
        chk("phase",   32'(bus.phase),   32'(ep));
    endtask

    task automatic reset_dut();
        rst          = 1'b1;
        bus.run      = 1'b1;
        bus.nmi_mask = 1'b0;
        bus.wdog_clr = 1'b0;
        step();
        step();
        cyc_check(0, 1, 0, 0);
        rst = 1'b0;
        cyc = 0;
    endtask

    function automatic int in_rng(input int c, input int lo, input int hi);
        return (c >= lo && c <= hi) ? 1 : 0;
    endfunction

    // Expected outputs for an undisturbed free run from cycle 1.
    function automatic int free_tick(input int c);
        return (c % 4 == 0) ? 1 : 0;
    endfunction

    // Expected outputs when the watchdog fires at event 224 (no clears).
    function automatic int wd_tick(input int c);
        if (c <= 224) return (c % 4 == 0) ? 1 : 0;
        return (c >= 234 && ((c - 230) % 4 == 0)) ? 1 : 0;
    endfunction

    function automatic int wd_phase(input int c);
        if (c <= 224) return (c / 4) % 14;
        if (c < 230) return 0;
        return ((c - 230) / 4) % 14;
    endfunction

    function automatic int wd_nmi(input int c);
        return (in_rng(c, 57, 59) + in_rng(c, 113, 115) + in_rng(c, 169, 171)) != 0 ? 0 : 1;
    endfunction

    initial begin
        int e;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst      = 1'b1;
        bus.run      = 1'b1;
        bus.nmi_mask = 1'b0;
        bus.wdog_clr = 1'b0;

        // Free run with periodic watchdog clears.
        reset_dut();
        for (int c = 1; c <= 120; c++) begin
            step();
            cyc_check(free_tick(c), (in_rng(c, 57, 59) + in_rng(c, 113, 115)) != 0 ? 0 : 1,
                      0, (c / 4) % 14);
            bus.wdog_clr = (c % 40 == 0) ? 1'b1 : 1'b0;
        end
        bus.wdog_clr = 1'b0;

        // Mask over cycles 50..60 drops the event at 56.
        reset_dut();
        for (int c = 1; c <= 120; c++) begin
            step();
            cyc_check(free_tick(c), in_rng(c, 113, 115) != 0 ? 0 : 1, 0, (c / 4) % 14);
            bus.nmi_mask = (c >= 50 && c <= 60) ? 1'b1 : 1'b0;
        end
        bus.nmi_mask = 1'b0;

        // No clears: watchdog expires at event 224.
        reset_dut();
        for (int c = 1; c <= 240; c++) begin
            step();
            cyc_check(wd_tick(c), wd_nmi(c), in_rng(c, 225, 229), wd_phase(c));
        end

        // Clear on each event cycle keeps the watchdog quiet.
        reset_dut();
        for (int c = 1; c <= 1000; c++) begin
            step();
            cyc_check(free_tick(c), (c > 56 && (c % 56) >= 1 && (c % 56) <= 3) ? 0 : 1,
                      0, (c / 4) % 14);
            bus.wdog_clr = (c % 56 == 0) ? 1'b1 : 1'b0;
        end
        bus.wdog_clr = 1'b0;

        // Pause mid-pulse for 20 cycles: pulse completes, counting shifts by 20.
        reset_dut();
        for (int c = 1; c <= 140; c++) begin
            step();
            e = (c <= 58) ? c : ((c <= 78) ? 58 : c - 20);
            cyc_check((c <= 58) ? free_tick(c) : ((c >= 79 && ((c - 20) % 4 == 0)) ? 1 : 0),
                      (in_rng(c, 57, 59) + in_rng(c, 133, 135)) != 0 ? 0 : 1,
                      0, (e / 4) % 14);
            bus.run = (c >= 58 && c <= 77) ? 1'b0 : 1'b1;
        end
        bus.run = 1'b1;

        // Reset mid-pulse, then timing restarts from cycle 1.
        reset_dut();
        for (int c = 1; c <= 58; c++) begin
            step();
            cyc_check(free_tick(c), in_rng(c, 57, 59) != 0 ? 0 : 1, 0, (c / 4) % 14);
        end
        rst = 1'b1;
        step();
        cyc_check(0, 1, 0, 0);
        rst = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            step();
            cyc_check(free_tick(c), in_rng(c, 57, 59) != 0 ? 0 : 1, 0, (c / 4) % 14);
        end

        // Reset mid watchdog reset, then timing restarts from cycle 1.
        reset_dut();
        for (int c = 1; c <= 227; c++) begin
            step();
            cyc_check(wd_tick(c), wd_nmi(c), in_rng(c, 225, 229), wd_phase(c));
        end
        rst = 1'b1;
        step();
        cyc_check(0, 1, 0, 0);
        rst = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            step();
            cyc_check(free_tick(c), in_rng(c, 57, 59) != 0 ? 0 : 1, 0, (c / 4) % 14);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
